universal_shift_reg_seq: RTL and testbench
==========================================

// Module: universal_shift_reg_seq
// PURPOSE
//  Parametrised universal shift register with a command handshake. One command does
//  hold, parallel load, or a multi-position left/right shift executed one bit per clock.
//  Busy/done flags and a shifted-out bit let a controller FSM sequence serial transfers
//  without counting cycles itself. Sits between datapath muxing and serial I/O logic.
// PARAMETERS
//  WIDTH      8   register width in bits (>=2)
//  CNT_W      4   width of shift-count field; max shift per command = 2**CNT_W-1
//  RESET_VAL  0   value of out while reset is asserted (WIDTH bits)
// PORTS
//  clk      in   1        rising-edge clock
//  reset    in   1        asynchronous, active-low reset
//  start    in   1        command strobe; accepted only when busy=0
//  mode     in   2        00 hold, 01 shift left (toward MSB), 10 shift right, 11 load
//  count    in   CNT_W    number of single-bit shifts (shift modes only)
//  par_in   in   WIDTH    parallel load data
//  in_l     in   1        serial bit entering LSB on shift left
//  in_r     in   1        serial bit entering MSB on shift right
//  abort    in   1        terminate an active shift command
//  rot      in   1        rotate instead of serial fill (ROTATE_EN builds only)
//  out      out  WIDTH    register contents
//  so_bit   out  1        bit dropped off the end by the most recent shift
//  busy     out  1        shift command in progress
//  done     out  1        one-cycle pulse: command completed
// BEHAVIOUR
//  - reset=0 (any time, incl. mid-command): out=RESET_VAL, so_bit=0, busy=0, done=0,
//    FSM=IDLE, remaining count=0. Takes effect immediately, not at the clock edge.
//  - FSM states: IDLE, SHIFT. done is registered, default 0 every cycle.
//  - IDLE, start=1 at edge E0 (command accepted):
//    mode 11: out<=par_in at E0; done=1 in cycle after E0; stay IDLE.
//    mode 00, or shift mode with count=0: out unchanged; done=1 after E0; stay IDLE.
//    mode 01/10, count=N>0: latch mode (and rot), rem<=N, busy<=1, go SHIFT; no shift at E0.
//  - SHIFT: one shift at each edge E1..EN; rem decrements per shift.
//    left:  out<={out[WIDTH-2:0], in_l}, so_bit<=out[WIDTH-1]
//    right: out<={in_r, out[WIDTH-1:1]}, so_bit<=out[0]
//    in_l/in_r sampled live at each shifting edge. At EN: busy<=0, done<=1, go IDLE.
//    busy is high exactly N cycles; done is the cycle after EN; next start accepted at EN+1.
//  - start while busy=1: ignored, no queuing; mode/count/par_in changes have no effect.
//  - abort=1 in SHIFT at edge Ek: no shift at Ek; busy<=0; go IDLE; done stays 0.
//    abort ignored in IDLE; abort and start at same edge in IDLE -> start wins.
//  - N>WIDTH legal: register fully refilled with serial data; so_bit tracks each drop.
//  - so_bit only updates on shifting edges; holds through load/hold commands.
// CONFIGURATION
//  ROTATE_EN defined: rot port exists; latched with command. rot=1 in shift modes
//    feeds the dropped bit back (left: LSB<=old MSB; right: MSB<=old LSB); in_l/in_r
//    ignored; so_bit still updated.
//  ROTATE_EN undefined: no rot port; shifts always use in_l/in_r fill.
// TESTING (WIDTH=8, CNT_W=4)
//  1 load: start, mode=11, par_in=8'hA5 -> out=A5 after E0, done=1 one cycle, busy stays 0
//  2 shift left N=3 from A5, in_l=1 -> out 4B,97,2F at E1..E3; busy=1 3 cycles;
//    done next cycle; so_bit=1
//  3 shift right N=2 from A5, in_r=0 -> out 52,29; so_bit=0; done after E2
//  4 from A5, shift left N=4, start pulsed again at E2 and abort=1 at E3 -> out=4B,97
//    then frozen; busy=0 after E3; done never; second start ignored
//  5 reset=0 asynchronously mid-shift (rem=5) -> out=00, busy=0, done=0, so_bit=0 before
//    next edge; after release, start mode=00 -> done pulse, out=00
//  6 ROTATE_EN: from A5, rot=1 right N=4 -> out=5A; left N=8 -> out=5A unchanged, done after E8

Source files
------------

// File: rtl/universal_shift_reg_seq.sv
// Universal shift register: hold / parallel load / multi-bit left or right shift, one bit per clock.
// Optional feature macro: ROTATE_EN adds the rot port (rotate instead of serial fill).
module universal_shift_reg_seq #(
    parameter int                 WIDTH     = 8,
    parameter int                 CNT_W     = 4,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  count,
    input  logic [WIDTH-1:0]  par_in,
    input  logic              in_l,
    input  logic              in_r,
    input  logic              abort,
`ifdef ROTATE_EN
    input  logic              rot,
`endif
    output logic [WIDTH-1:0]  out,
    output logic              so_bit,
    output logic              busy,
    output logic              done
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_LEFT  = 2'b01;
    localparam logic [1:0] MODE_RIGHT = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               so_q, so_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               left_q, left_d;
    logic               rot_q, rot_d;
    logic               rot_cmd;
    logic               fill_bit;

`ifdef ROTATE_EN
    assign rot_cmd = rot;
`else
    assign rot_cmd = 1'b0;
`endif

    // Bit entering the vacated end: the dropped bit when rotating, else live serial input.
    always_comb begin
        fill_bit = 1'b0;
        if (left_q) begin
            fill_bit = rot_q ? out_q[WIDTH-1] : in_l;
        end else begin
            fill_bit = rot_q ? out_q[0] : in_r;
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        so_d    = so_q;
        done_d  = 1'b0;
        rem_d   = rem_q;
        left_d  = left_q;
        rot_d   = rot_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (mode)
                        MODE_LOAD: begin
                            out_d  = par_in;
                            done_d = 1'b1;
                        end
                        MODE_LEFT, MODE_RIGHT: begin
                            if (count == '0) begin
                                done_d = 1'b1;
                            end else begin
                                state_d = SHIFT;
                                rem_d   = count;
                                left_d  = (mode == MODE_LEFT);
                                rot_d   = rot_cmd;
                            end
                        end
                        MODE_HOLD: done_d = 1'b1;
                        default:   done_d = 1'b1;
                    endcase
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                    rem_d   = '0;
                end else begin
                    if (left_q) begin
                        out_d = {out_q[WIDTH-2:0], fill_bit};
                        so_d  = out_q[WIDTH-1];
                    end else begin
                        out_d = {fill_bit, out_q[WIDTH-1:1]};
                        so_d  = out_q[0];
                    end
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            out_q   <= RESET_VAL;
            so_q    <= 1'b0;
            done_q  <= 1'b0;
            rem_q   <= '0;
            left_q  <= 1'b0;
            rot_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            so_q    <= so_d;
            done_q  <= done_d;
            rem_q   <= rem_d;
            left_q  <= left_d;
            rot_q   <= rot_d;
        end
    end

    assign out    = out_q;
    assign so_bit = so_q;
    assign busy   = (state_q == SHIFT);
    assign done   = done_q;

endmodule

// File: tb/tb_universal_shift_reg_seq.sv
// Directed testbench for universal_shift_reg_seq (WIDTH=8, CNT_W=4); rotate cases need ROTATE_EN.
module tb_universal_shift_reg_seq;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] mode;
    logic [3:0] count;
    logic [7:0] par_in;
    logic       in_l;
    logic       in_r;
    logic       abort;
`ifdef ROTATE_EN
    logic       rot;
`endif
    logic [7:0] out;
    logic       so_bit;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fails  = 0;

    universal_shift_reg_seq #(.WIDTH(8), .CNT_W(4), .RESET_VAL(8'h00)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mode   (mode),
        .count  (count),
        .par_in (par_in),
        .in_l   (in_l),
        .in_r   (in_r),
        .abort  (abort),
`ifdef ROTATE_EN
        .rot    (rot),
`endif
        .out    (out),
        .so_bit (so_bit),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] m, input logic [3:0] n, input logic [7:0] d);
        start  = 1'b1;
        mode   = m;
        count  = n;
        par_in = d;
        tick();
        start  = 1'b0;
    endtask

    task automatic load_a5();
        issue(2'b11, 4'd0, 8'hA5);
        tick();
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; mode = 2'b00; count = '0; par_in = '0;
        in_l = 1'b0; in_r = 1'b0; abort = 1'b0;
`ifdef ROTATE_EN
        rot = 1'b0;
`endif
        #3;
        check("rst_out",  out,    8'h00);
        check("rst_busy", busy,   1'b0);
        check("rst_done", done,   1'b0);
        check("rst_so",   so_bit, 1'b0);
        tick();
        reset = 1'b1;
        tick();

        // 1: parallel load
        issue(2'b11, 4'd0, 8'hA5);
        check("ld_out",  out,  8'hA5);
        check("ld_done", done, 1'b1);
        check("ld_busy", busy, 1'b0);
        tick();
        check("ld_done_clr", done, 1'b0);

        // 2: shift left by 3, in_l=1
        in_l = 1'b1;
        issue(2'b01, 4'd3, 8'h00);
        check("sl_e0_out",  out,  8'hA5);
        check("sl_e0_busy", busy, 1'b1);
        tick(); check("sl_e1_out", out, 8'h4B); check("sl_e1_so", so_bit, 1'b1);
        tick(); check("sl_e2_out", out, 8'h97); check("sl_e2_busy", busy, 1'b1);
        check("sl_e2_done", done, 1'b0);
        tick(); check("sl_e3_out", out, 8'h2F); check("sl_e3_so", so_bit, 1'b1);
        check("sl_e3_busy", busy, 1'b0); check("sl_e3_done", done, 1'b1);
        tick(); check("sl_done_clr", done, 1'b0); check("sl_hold", out, 8'h2F);

        // 3: shift right by 2, in_r=0
        load_a5();
        check("ld_keeps_so", so_bit, 1'b1);
        in_r = 1'b0;
        issue(2'b10, 4'd2, 8'h00);
        tick(); check("sr_e1_out", out, 8'h52); check("sr_e1_so", so_bit, 1'b1);
        tick(); check("sr_e2_out", out, 8'h29); check("sr_e2_so", so_bit, 1'b0);
        check("sr_e2_done", done, 1'b1); check("sr_e2_busy", busy, 1'b0);
        tick();

        // 4: start ignored while busy, abort mid-command
        load_a5();
        in_l = 1'b1;
        issue(2'b01, 4'd4, 8'h00);
        tick(); check("ab_e1_out", out, 8'h4B);
        start = 1'b1; mode = 2'b11; par_in = 8'hFF; count = 4'd1;
        tick(); start = 1'b0;
        check("ab_e2_out", out, 8'h97); check("ab_e2_busy", busy, 1'b1);
        abort = 1'b1;
        tick(); abort = 1'b0;
        check("ab_e3_out", out, 8'h97); check("ab_e3_busy", busy, 1'b0);
        check("ab_e3_done", done, 1'b0);
        tick(); check("ab_after_out", out, 8'h97); check("ab_after_done", done, 1'b0);

        // shift command with count=0 completes immediately without shifting
        issue(2'b10, 4'd0, 8'h00);
        check("c0_out", out, 8'h97); check("c0_done", done, 1'b1); check("c0_busy", busy, 1'b0);
        tick();

        // 5: asynchronous reset mid-shift (rem=5)
        load_a5();
        in_l = 1'b0;
        issue(2'b01, 4'd8, 8'h00);
        tick(); tick(); tick();
        check("ar_pre_out", out, 8'h28);
        #2 reset = 1'b0;
        #1;
        check("ar_out",  out,    8'h00);
        check("ar_busy", busy,   1'b0);
        check("ar_done", done,   1'b0);
        check("ar_so",   so_bit, 1'b0);
        #1 reset = 1'b1;
        tick();
        check("ar_idle_busy", busy, 1'b0);
        issue(2'b00, 4'd5, 8'hFF);
        check("hold_done", done, 1'b1); check("hold_out", out, 8'h00);
        tick();

`ifdef ROTATE_EN
        // 6: rotate right by 4, then rotate left by 8
        load_a5();
        rot = 1'b1; in_l = 1'b0; in_r = 1'b1;
        issue(2'b10, 4'd4, 8'h00);
        rot = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("rr_out", out, 8'h5A); check("rr_done", done, 1'b1);
        tick();
        rot = 1'b1;
        issue(2'b01, 4'd8, 8'h00);
        rot = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("rl_e7_done", done, 1'b0);
        tick();
        check("rl_out", out, 8'h5A); check("rl_done", done, 1'b1);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
